sdram_arbiter: RTL and testbench

- Shares the single SDRAM request port (read/write/address/data/finished handshake) among `NUM_REQ` requesters, e.g. mix core, record core and playback core.
- Uses round-robin arbitration and holds each grant for exactly one transaction, until `sdram_finished`.
- A watchdog aborts transactions the SDRAM never completes.
- Sits between the audio-processing cores and the SDRAM controller wrapper.

---
 rtl/sdram_arbiter_if.sv | 47 ++++
 rtl/sdram_arbiter.sv | 142 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// Requester-side and SDRAM-side signals of the SDRAM arbiter, bundled as one interface.
// slave modport: the arbiter's view (requests/SDRAM replies in, strobes/status out).
// master modport: the surrounding system's view (requesters plus SDRAM controller).
interface sdram_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 23
);
  localparam int IDW = $clog2(NUM_REQ);

  // requester side
  logic [NUM_REQ-1:0]             req_read;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][31:0]       req_writedata;
  logic [31:0]                    req_readdata;
  logic [NUM_REQ-1:0]             req_finished;

  // SDRAM controller side
  logic                           sdram_read;
  logic                           sdram_write;
  logic [ADDR_W-1:0]              sdram_addr;
  logic [31:0]                    sdram_writedata;
  logic [31:0]                    sdram_readdata;
  logic                           sdram_finished;

  // status
  logic [IDW-1:0]                 grant_id;
  logic                           busy;
  logic                           timeout_err;
  logic [IDW-1:0]                 timeout_id;

  modport slave (
    input  req_read, req_write, req_addr, req_writedata,
    input  sdram_readdata, sdram_finished,
    output req_readdata, req_finished,
    output sdram_read, sdram_write, sdram_addr, sdram_writedata,
    output grant_id, busy, timeout_err, timeout_id
  );

  modport master (
    output req_read, req_write, req_addr, req_writedata,
    output sdram_readdata, sdram_finished,
    input  req_readdata, req_finished,
    input  sdram_read, sdram_write, sdram_addr, sdram_writedata,
    input  grant_id, busy, timeout_err, timeout_id
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM request port among NUM_REQ requesters, one transaction per grant.
// Latency: request seen in IDLE at t -> strobe from t+1; req_finished same cycle as sdram_finished; >=3 cycles/transaction.
// Backpressure: requests are levels held until req_finished; a watchdog abandons grants the SDRAM never finishes.
//
// Ports:
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   bus (slave)    : req_read/req_write/req_addr/req_writedata in, req_readdata/req_finished out;
//                    sdram_read/sdram_write/sdram_addr/sdram_writedata out, sdram_readdata/sdram_finished in;
//                    grant_id, busy, timeout_err, timeout_id status out
module sdram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 1023
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  sdram_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [IDW:0]   NREQ    = (IDW+1)'(NUM_REQ);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             state_q;
  logic [IDW-1:0]     last_q;
  logic [IDW-1:0]     grant_id_q;
  logic [IDW-1:0]     timeout_id_q;
  logic [WDW-1:0]     wdog_q;
  logic               rd_q;
  logic               wr_q;
  logic               busy_q;
  logic               terr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;

  logic [NUM_REQ-1:0] pend;
  logic               win_vld;
  logic [IDW-1:0]     win_idx;
  logic [IDW:0]       rr_sum;

  assign pend = bus.req_read | bus.req_write;

  // Search last+1, last+2, ... wrapping at NUM_REQ; the first pending index wins.
  // last < NUM_REQ and k <= NUM_REQ, so one conditional subtract is enough for the wrap.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_sum  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = {1'b0, last_q} + (IDW+1)'(k);
      if (rr_sum >= NREQ) begin
        rr_sum = rr_sum - NREQ;
      end
      if (!win_vld && pend[rr_sum[IDW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = rr_sum[IDW-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      last_q       <= IDW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      timeout_id_q <= '0;
      wdog_q       <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      busy_q       <= 1'b0;
      terr_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            grant_id_q <= win_idx;
            last_q     <= win_idx;
            // write wins when both op bits are set
            wr_q       <= bus.req_write[win_idx];
            rd_q       <= !bus.req_write[win_idx];
            addr_q     <= bus.req_addr[win_idx];
            wdata_q    <= bus.req_writedata[win_idx];
            busy_q     <= 1'b1;
            state_q    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          wdog_q <= wdog_q + WDW'(1);
          // completion takes priority over the watchdog in the final allowed cycle
          if (bus.sdram_finished || (wdog_q == WD_LAST)) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_RELEASE;
            if (!bus.sdram_finished) begin
              terr_q <= 1'b1;
              // keep the index of the first offender only
              if (!terr_q) begin
                timeout_id_q <= grant_id_q;
              end
            end
          end
        end
        ST_RELEASE: begin
          wdog_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Completion is passed through combinationally, gated by GRANT so stray finishes are dropped.
  always_comb begin
    bus.req_finished = '0;
    if ((state_q == ST_GRANT) && bus.sdram_finished) begin
      bus.req_finished[grant_id_q] = 1'b1;
    end
  end

  assign bus.req_readdata    = bus.sdram_readdata;
  assign bus.sdram_read      = rd_q;
  assign bus.sdram_write     = wr_q;
  assign bus.sdram_addr      = addr_q;
  assign bus.sdram_writedata = wdata_q;
  assign bus.grant_id        = grant_id_q;
  assign bus.busy            = busy_q;
  assign bus.timeout_err     = terr_q;
  assign bus.timeout_id      = timeout_id_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: reset values, vector table of single transactions,
// round-robin / capture / stray-finish / timeout / reset sequences, then randomized traffic
// checked against a transaction-level reference model.
module tb_sdram_arbiter;
  localparam int NR = 3;
  localparam int AW = 23;
  localparam int TO = 8;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  sdram_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus ();

  sdram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not end, at time %0t", $time);
    $fatal(1);
  end

  typedef struct {
    int          id;
    logic        rd;
    logic        wr;
    logic [22:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        exp_rd;
    logic        exp_wr;
    logic [2:0]  exp_fin;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next_cyc();
  endtask

  task automatic clear_inputs();
    bus.req_read       = '0;
    bus.req_write      = '0;
    bus.req_addr       = '0;
    bus.req_writedata  = '0;
    bus.sdram_finished = 1'b0;
  endtask

  task automatic wait_busy(input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      next_cyc();
      #3;
      if (bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"},    bus.sdram_read, 0);
    chk({tag, "_wr"},    bus.sdram_write, 0);
    chk({tag, "_addr"},  bus.sdram_addr, 0);
    chk({tag, "_wdata"}, bus.sdram_writedata, 0);
    chk({tag, "_fin"},   bus.req_finished, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_gid"},   bus.grant_id, 0);
    chk({tag, "_terr"},  bus.timeout_err, 0);
    chk({tag, "_tid"},   bus.timeout_id, 0);
  endtask

  task automatic reset_pulse();
    next_cyc();
    clear_inputs();
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    next_cyc();
    bus.req_read[v.id]      = v.rd;
    bus.req_write[v.id]     = v.wr;
    bus.req_addr[v.id]      = v.addr;
    bus.req_writedata[v.id] = v.wdata;
    bus.sdram_readdata      = ~v.rdata;
    #3;
    chk("vec_idle_busy", bus.busy, 0);
    for (int k = 1; k <= v.lat; k++) begin
      next_cyc();
      if (k == v.lat) begin
        bus.sdram_finished = 1'b1;
        bus.sdram_readdata = v.rdata;
      end
      #3;
      chk("vec_rd",    bus.sdram_read, v.exp_rd);
      chk("vec_wr",    bus.sdram_write, v.exp_wr);
      chk("vec_addr",  bus.sdram_addr, v.addr);
      chk("vec_wdata", bus.sdram_writedata, v.wdata);
      chk("vec_gid",   bus.grant_id, v.id);
      chk("vec_busy",  bus.busy, 1);
      chk("vec_fin",   bus.req_finished, (k == v.lat) ? v.exp_fin : 3'b000);
      if (k == v.lat) chk("vec_rdata", bus.req_readdata, v.rdata);
    end
    next_cyc();
    bus.req_read[v.id]  = 1'b0;
    bus.req_write[v.id] = 1'b0;
    bus.sdram_finished  = 1'b0;
    #3;
    chk("vec_rel_rd",   bus.sdram_read, 0);
    chk("vec_rel_wr",   bus.sdram_write, 0);
    chk("vec_rel_busy", bus.busy, 0);
    chk("vec_rel_fin",  bus.req_finished, 0);
  endtask

  // Counts GRANT cycles with a strobe until it drops; the caller has already seen the first one.
  task automatic count_strobe(output int cnt);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      next_cyc();
      #3;
      chk("to_nofin", bus.req_finished, 0);
      if (!(bus.sdram_read || bus.sdram_write)) break;
      cnt++;
    end
  endtask

  // reference model state for the random phase
  bit          m_act, m_pend, m_wr, fin;
  int          m_free, m_last, m_gid, m_fin_at, w, idx, prev, cnt;
  logic [22:0] m_addr;
  logic [31:0] m_data, rdat;
  logic [2:0]  ef;
  bit   [2:0]  hold;
  logic [1:0]  op;
  bit          ok;

  initial begin
    vecs[0] = '{1, 1'b1, 1'b0, 23'h000123, 32'h0000_0000, 4, 32'hDEAD_BEEF, 1'b1, 1'b0, 3'b010};
    vecs[1] = '{2, 1'b1, 1'b1, 23'h7F_FFFF, 32'h1234_5678, 2, 32'h0000_0001, 1'b0, 1'b1, 3'b100};
    vecs[2] = '{0, 1'b0, 1'b1, 23'h000000, 32'hA5A5_A5A5, 1, 32'h5A5A_5A5A, 1'b0, 1'b1, 3'b001};
    vecs[3] = '{1, 1'b0, 1'b1, 23'h2A_AAAA, 32'hFFFF_FFFF, 7, 32'h8000_0000, 1'b0, 1'b1, 3'b010};

    rst_n = 1'b0;
    clear_inputs();
    bus.sdram_readdata = 32'h0BAD_F00D;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    chk("rst_rdata", bus.req_readdata, 32'h0BAD_F00D);
    rst_n = 1'b1;

    // round-robin: all hold reads, SDRAM finishes in the first GRANT cycle
    next_cyc();
    bus.req_read    = 3'b111;
    bus.req_addr[0] = 23'h000100;
    bus.req_addr[1] = 23'h000200;
    bus.req_addr[2] = 23'h000300;
    prev = 0;
    for (int j = 0; j < 6; j++) begin
      wait_busy(8, ok);
      chk("rr_wait", ok, 1);
      chk("rr_gid", bus.grant_id, j % 3);
      chk("rr_addr", bus.sdram_addr, (j % 3 + 1) * 256);
      chk("rr_rd", bus.sdram_read, 1);
      if (j > 0) chk("rr_gap", cyc - prev, 3);
      prev = cyc;
      bus.sdram_finished = 1'b1;
      #1;
      chk("rr_fin", bus.req_finished, 3'b001 << (j % 3));
      next_cyc();
      bus.sdram_finished = 1'b0;
    end
    bus.req_read = '0;

    // vector table of single transactions
    for (int v = 0; v < 4; v++) begin
      idle(2);
      run_vec(vecs[v]);
    end

    // capture: changes after the grant do not reach the SDRAM side
    idle(2);
    next_cyc();
    bus.req_read[2]      = 1'b1;
    bus.req_write[2]     = 1'b1;
    bus.req_writedata[2] = 32'h1234_5678;
    bus.req_addr[2]      = 23'h055AA5;
    wait_busy(4, ok);
    chk("cap_wait", ok, 1);
    chk("cap_wr0", bus.sdram_write, 1);
    chk("cap_rd0", bus.sdram_read, 0);
    chk("cap_wdata0", bus.sdram_writedata, 32'h1234_5678);
    bus.req_writedata[2] = 32'hCAFE_F00D;
    bus.req_addr[2]      = 23'h000000;
    bus.req_write[2]     = 1'b0;
    repeat (2) begin
      next_cyc();
      #3;
      chk("cap_wdata", bus.sdram_writedata, 32'h1234_5678);
      chk("cap_addr", bus.sdram_addr, 23'h055AA5);
      chk("cap_wr", bus.sdram_write, 1);
      chk("cap_rd", bus.sdram_read, 0);
    end
    next_cyc();
    bus.sdram_finished = 1'b1;
    #3;
    chk("cap_fin", bus.req_finished, 3'b100);
    next_cyc();
    bus.sdram_finished = 1'b0;
    bus.req_read[2]    = 1'b0;

    // stray finish in IDLE
    idle(2);
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      bus.sdram_finished = 1'b1;
      #3;
      chk("stray_fin", bus.req_finished, 0);
      chk("stray_busy", bus.busy, 0);
      chk("stray_rd", bus.sdram_read, 0);
    end
    next_cyc();
    bus.sdram_finished = 1'b0;

    // randomized traffic against the transaction-level model
    reset_pulse();
    m_act = 0; m_pend = 0; m_free = 0; m_last = NR - 1; m_gid = 0; m_wr = 0;
    m_fin_at = 0; m_addr = '0; m_data = '0; hold = '0;
    for (int n = 0; n < 1500; n++) begin
      next_cyc();
      if (m_pend) begin
        m_act  = 1'b1;
        m_pend = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        if (!hold[i] && ($urandom_range(0, 3) == 0)) hold[i] = 1'b1;
        if (hold[i]) begin
          op = 2'($urandom_range(1, 3));
          bus.req_read[i]  = op[0];
          bus.req_write[i] = op[1];
          if ($urandom_range(0, 1) == 1) begin
            bus.req_addr[i]      = 23'($urandom);
            bus.req_writedata[i] = $urandom;
          end
        end else begin
          bus.req_read[i]  = 1'b0;
          bus.req_write[i] = 1'b0;
        end
      end
      rdat = $urandom;
      bus.sdram_readdata = rdat;
      fin = m_act ? (n == m_fin_at) : ($urandom_range(0, 4) == 0);
      bus.sdram_finished = fin;
      #3;
      ef = (m_act && fin) ? 3'(1 << m_gid) : 3'b000;
      chk("rnd_rd",    bus.sdram_read, m_act && !m_wr);
      chk("rnd_wr",    bus.sdram_write, m_act && m_wr);
      chk("rnd_busy",  bus.busy, m_act);
      chk("rnd_fin",   bus.req_finished, ef);
      chk("rnd_rdata", bus.req_readdata, rdat);
      chk("rnd_gid",   bus.grant_id, m_gid);
      chk("rnd_terr",  bus.timeout_err, 0);
      if (m_act) begin
        chk("rnd_addr",  bus.sdram_addr, m_addr);
        chk("rnd_wdata", bus.sdram_writedata, m_data);
      end
      if (m_act && fin) begin
        m_act        = 1'b0;
        m_free       = n + 2;
        hold[m_gid]  = 1'b0;
      end else if (!m_act && !m_pend && (n >= m_free) && ((bus.req_read | bus.req_write) != 0)) begin
        w = -1;
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (w < 0 && (bus.req_read[idx] || bus.req_write[idx])) w = idx;
        end
        m_gid    = w;
        m_last   = w;
        m_wr     = bus.req_write[w];
        m_addr   = bus.req_addr[w];
        m_data   = bus.req_writedata[w];
        m_pend   = 1'b1;
        m_fin_at = n + $urandom_range(1, 6);
      end
    end

    // watchdog: req 0 never finishes, req 1 waits behind it
    reset_pulse();
    idle(1);
    next_cyc();
    bus.req_read[0] = 1'b1;
    bus.req_addr[0] = 23'h0000AA;
    wait_busy(4, ok);
    chk("to_wait0", ok, 1);
    chk("to_gid0", bus.grant_id, 0);
    bus.req_read[1] = 1'b1;
    bus.req_addr[1] = 23'h0000BB;
    count_strobe(cnt);
    chk("to_len0", cnt, TO);
    chk("to_terr0", bus.timeout_err, 1);
    chk("to_tid0", bus.timeout_id, 0);
    chk("to_busy0", bus.busy, 0);
    wait_busy(4, ok);
    chk("to_wait1", ok, 1);
    chk("to_gid1", bus.grant_id, 1);
    chk("to_addr1", bus.sdram_addr, 23'h0000BB);
    count_strobe(cnt);
    chk("to_len1", cnt, TO);
    chk("to_tid_first", bus.timeout_id, 0);
    chk("to_terr_sticky", bus.timeout_err, 1);
    wait_busy(4, ok);
    chk("to_wait2", ok, 1);
    chk("to_gid2", bus.grant_id, 0);

    // asynchronous reset in the middle of a grant
    next_cyc();
    bus.sdram_finished = 1'b1;
    #1;
    chk("prerst_fin", bus.req_finished, 3'b001);
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    bus.req_read       = 3'b111;
    bus.sdram_finished = 1'b0;
    idle(2);
    rst_n = 1'b1;
    wait_busy(4, ok);
    chk("post_rst_wait", ok, 1);
    chk("post_rst_gid", bus.grant_id, 0);
    chk("post_rst_rd", bus.sdram_read, 1);
    bus.sdram_finished = 1'b1;
    #1;
    chk("post_rst_fin", bus.req_finished, 3'b001);
    next_cyc();
    clear_inputs();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
